mc_sequencer: RTL

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer_pkg.sv | 78 +++++++
 rtl/mc_sequencer_if.sv | 40 ++++
 rtl/mc_sequencer_wait_timer.sv | 31 +++
 rtl/mc_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, state codes,
// mux-select and error encodings, and the bundled control-strobe payload.
package mc_sequencer_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned STATE_W = 4;

  // RV32I major opcodes
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  // Sequencer states
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t S_FETCH      = 4'd0;
  localparam state_t S_FETCH_WAIT = 4'd1;
  localparam state_t S_DECODE     = 4'd2;
  localparam state_t S_EXEC       = 4'd3;
  localparam state_t S_BR_TGT     = 4'd4;
  localparam state_t S_BR_CMP     = 4'd5;
  localparam state_t S_MEM        = 4'd6;
  localparam state_t S_MEM_WAIT   = 4'd7;
  localparam state_t S_WB         = 4'd8;
  localparam state_t S_HALT       = 4'd9;

  // Mux selects
  localparam logic [SEL_W-1:0] A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] A_RS1   = 2'b01;
  localparam logic [SEL_W-1:0] B_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] B_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] B_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] WB_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM  = 2'b01;
  localparam logic [SEL_W-1:0] WB_IMM  = 2'b10;
  localparam logic [SEL_W-1:0] WB_PC4  = 2'b11;
  localparam logic             PC_SEQ  = 1'b0;
  localparam logic             PC_TGT  = 1'b1;

  // Halt causes
  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [ERR_W-1:0] ERR_IMEM    = 2'b10;
  localparam logic [ERR_W-1:0] ERR_DMEM    = 2'b11;

  // Datapath control bundle driven by the sequencer each cycle
  typedef struct packed {
    logic             imem_req;
    logic             dmem_req;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             dmem_wren;
    logic             br_tgt_write;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] writeback_src;
    logic             pc_src;
  } ctrl_t;

  // Opcodes the sequencer knows how to execute
  function automatic logic opc_is_legal(input logic [OPC_W-1:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP_IMM,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
// master: sequencer (drives reqs, strobes, selects, status)
// slave : datapath/memory side (drives decoded fields, branch result, readies)
interface mc_sequencer_if;
  import mc_sequencer_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;
  logic             br_taken;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             dmem_wren;
  logic             br_tgt_write;
  logic [SEL_W-1:0] alu_src_a;
  logic [SEL_W-1:0] alu_src_b;
  logic [SEL_W-1:0] writeback_src;
  logic             pc_src;
  logic             halted;
  logic [ERR_W-1:0] err_code;

  modport master (
    input  opcode, funct3, br_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, pc_write, ir_write, reg_write, dmem_wren,
           br_tgt_write, alu_src_a, alu_src_b, writeback_src, pc_src,
           halted, err_code
  );

  modport slave (
    output opcode, funct3, br_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, pc_write, ir_write, reg_write, dmem_wren,
           br_tgt_write, alu_src_a, alu_src_b, writeback_src, pc_src,
           halted, err_code
  );

endinterface

// File: rtl/mc_sequencer_wait_timer.sv
// Handshake wait timer: clears on state entry, counts while enabled,
// saturates at all-ones, flags the TIMEOUT-th enabled cycle.
// Ports: clk, reset, clr (state change), en (in a wait state), timeout_c.
module mc_sequencer_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter is zero in the first cycle of each state
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout_c = en && (cnt >= LIMIT);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer.
// Ports: clk, reset (sync, active-high), bus (mc_sequencer_if.master:
// decoded fields and readies in; handshake reqs, datapath strobes,
// mux selects, halted/err_code out).
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_sequencer_if.master       bus
);

  state_t           state, state_n;
  logic [OPC_W-1:0] op_q;
  logic [ERR_W-1:0] err_q, err_n;
  ctrl_t            ctrl, ctrl_o;
  logic             timeout_c;

  // Instruction class of the opcode latched in DECODE
  logic is_load, is_store, is_op, is_op_imm, is_lui, is_auipc, is_jal, is_jalr;
  assign is_load   = (op_q == OPC_LOAD);
  assign is_store  = (op_q == OPC_STORE);
  assign is_op     = (op_q == OPC_OP);
  assign is_op_imm = (op_q == OPC_OP_IMM);
  assign is_lui    = (op_q == OPC_LUI);
  assign is_auipc  = (op_q == OPC_AUIPC);
  assign is_jal    = (op_q == OPC_JAL);
  assign is_jalr   = (op_q == OPC_JALR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Latched opcode and sticky halt cause
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      err_q <= ERR_NONE;
    end else begin
      err_q <= err_n;
      if (state == S_DECODE) op_q <= bus.opcode;
    end
  end

  mc_sequencer_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_n != state),
    .en        ((state == S_FETCH_WAIT) || (state == S_MEM_WAIT)),
    .timeout_c (timeout_c)
  );

  // Next state and control decode
  always_comb begin
    state_n = state;
    err_n   = err_q;
    ctrl    = '0;
    case (state)
      S_FETCH, S_FETCH_WAIT: begin
        ctrl.imem_req = 1'b1;
        if (bus.imem_ready) begin
          ctrl.ir_write = 1'b1;
          state_n       = S_DECODE;
        end else if (state == S_FETCH) begin
          state_n = S_FETCH_WAIT;
        end else if (timeout_c) begin
          state_n = S_HALT;
          err_n   = ERR_IMEM;
        end
      end
      S_DECODE: begin
        if (bus.opcode == OPC_BRANCH) begin
          state_n = S_BR_TGT;
        end else if (opc_is_legal(bus.opcode)) begin
          state_n = S_EXEC;
        end else begin
          state_n = S_HALT;
          err_n   = ERR_ILLEGAL;
        end
      end
      S_BR_TGT: begin
        ctrl.alu_src_a    = A_PC;
        ctrl.alu_src_b    = B_IMM;
        ctrl.br_tgt_write = 1'b1;
        state_n           = S_BR_CMP;
      end
      S_BR_CMP: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = bus.br_taken ? PC_TGT : PC_SEQ;
        state_n        = S_FETCH;
      end
      S_EXEC: begin
        if (is_op) begin
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_RS2;
        end else if (is_op_imm || is_load || is_store || is_jalr) begin
          ctrl.alu_src_a = A_RS1;
          ctrl.alu_src_b = B_IMM;
        end else if (is_auipc || is_jal) begin
          ctrl.alu_src_a = A_PC;
          ctrl.alu_src_b = B_IMM;
        end
        state_n = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM, S_MEM_WAIT: begin
        ctrl.dmem_req  = 1'b1;
        ctrl.dmem_wren = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SEQ;
            state_n       = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (state == S_MEM) begin
          state_n = S_MEM_WAIT;
        end else if (timeout_c) begin
          state_n = S_HALT;
          err_n   = ERR_DMEM;
        end
      end
      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        if (is_load)                 ctrl.writeback_src = WB_MEM;
        else if (is_lui)             ctrl.writeback_src = WB_IMM;
        else if (is_jal || is_jalr)  ctrl.writeback_src = WB_PC4;
        else                         ctrl.writeback_src = WB_ALU;
        ctrl.pc_src = (is_jal || is_jalr) ? PC_TGT : PC_SEQ;
        state_n     = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Reset blanks every strobe in its own cycle so an abandoned handshake writes nothing
  assign ctrl_o = reset ? '0 : ctrl;

  assign bus.imem_req      = ctrl_o.imem_req;
  assign bus.dmem_req      = ctrl_o.dmem_req;
  assign bus.ir_write      = ctrl_o.ir_write;
  assign bus.pc_write      = ctrl_o.pc_write;
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.dmem_wren     = ctrl_o.dmem_wren;
  assign bus.br_tgt_write  = ctrl_o.br_tgt_write;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.writeback_src = ctrl_o.writeback_src;
  assign bus.pc_src        = ctrl_o.pc_src;
  assign bus.halted        = (state == S_HALT);
  assign bus.err_code      = err_q;

endmodule
